// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: default width, select codes
// and the bit layout of a buffered result entry.
package alu_result_stage_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

    // Entry layout, LSB first: neg, zero, y[WIDTH-1:0], sel[1:0]
    localparam int unsigned ENTRY_EXTRA = 4;
    localparam int unsigned NEG_BIT     = 0;
    localparam int unsigned ZERO_BIT    = 1;
    localparam int unsigned Y_LSB       = 2;

    function automatic int unsigned entry_width(input int unsigned width);
        return width + ENTRY_EXTRA;
    endfunction

endpackage

// File: rtl/alu_result_stage_result_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and occupancy.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module result_fifo
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Write the incoming entry at the write pointer; reset cycle writes nothing
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head reads as zero while nothing is buffered
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: tags each accepted result with its select code and
// zero/negative flags, buffers it for the consumer, keeps the last accepted
// result as a feedback operand and counts offers refused while full.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_y,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] last_y,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned EW = entry_width(WIDTH);

    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags are computed at enqueue so the head fields are pure storage reads
    always_comb begin
        wr_entry                       = '0;
        wr_entry[NEG_BIT]              = in_y[WIDTH-1];
        wr_entry[ZERO_BIT]             = (in_y == '0);
        wr_entry[Y_LSB +: WIDTH]       = in_y;
        wr_entry[Y_LSB + WIDTH +: 2]   = in_sel;
    end

    result_fifo #(
        .DATA_W (EW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign out_neg  = head[NEG_BIT];
    assign out_zero = head[ZERO_BIT];
    assign out_data = head[Y_LSB +: WIDTH];
    assign out_sel  = head[Y_LSB + WIDTH +: 2];

    // Feedback operand: capture every accepted result, independent of pops
    always_ff @(posedge clk) begin
        if (rst) begin
            last_y <= '0;
        end else if (push) begin
            last_y <= in_y;
        end
    end

    // Saturating count of cycles where the producer was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Downstream stage of the 8-bit ALU select mux. It captures the selected ALU result each time the producer presents it, tags each result with its select code and status flags, and buffers results in a small FIFO for the consumer (register file / bus) through a valid/ready handshake. It also holds the last accepted result as a feedback operand for the ALU and counts results the producer offered while the stage was full.

Parameters:
WIDTH, 8, data width of the ALU result
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_y  input  WIDTH  ALU mux result
in_sel  input  2  select code that produced in_y
in_valid  input  1  producer asserts when in_y/in_sel are valid
in_ready  output  1  stage can accept this cycle
out_data  output  WIDTH  head-of-FIFO result
out_sel  output  2  head-of-FIFO select tag
out_zero  output  1  head result == 0
out_neg  output  1  head result MSB
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
last_y  output  WIDTH  last accepted result, feedback operand to ALU
drop_cnt  output  CNT_W  saturating count of refused offers

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): FIFO empty, read and write pointers 0, occupancy 0. last_y = 0, drop_cnt = 0. out_valid = 0 and in_ready = 1 on the first cycle after reset. out_data, out_sel, out_zero and out_neg read as 0 while empty.
- Push: when in_valid && in_ready. Entry {in_sel, in_y, zero = (in_y == 0), neg = in_y[WIDTH-1]} is written at the write pointer. Flags are computed at enqueue, not at dequeue.
- Pop: when out_valid && out_ready. The read pointer advances.
- in_ready = (occupancy < DEPTH). It is registered-state based only, with no combinational path from out_ready. A full FIFO refuses a push even if a pop occurs in the same cycle.
- out_valid = (occupancy != 0). Head fields are driven from the storage entry at the read pointer.
- Latency: a push at cycle N is visible at the outputs in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop while non-empty and not full: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Occupancy is held in log2(DEPTH)+1 bits and never exceeds DEPTH or goes below 0.
- last_y takes in_y on every push and holds otherwise. It is independent of pops.
- drop_cnt increments on each cycle with in_valid && !in_ready. It saturates at all-ones.
- Reset asserted mid-transfer discards all buffered entries. The push or pop in the reset cycle has no effect.
- Pop while empty, or push while full, is ignored. No pointer or occupancy change occurs.

Decomposition:
- Shared package:
  - WIDTH default.
  - Select-code constants SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11.
  - FIFO entry field layout (sel, y, zero, neg), entry width WIDTH+4.
- One sub-module, result_fifo:
  - Parameterised storage, pointers and occupancy.
  - Exposes push/pop/full/empty/head.
- The top level adds:
  - Flag generation.
  - last_y register.
  - drop_cnt.
  - Handshake mapping.

Test Plan:
1. Reset then idle. Expect out_valid = 0, in_ready = 1, last_y = 0, drop_cnt = 0, all head outputs 0.
2. Single push of in_y = 8'h00 with sel 2'b10, out_ready = 0. Next cycle expect out_valid = 1, out_data = 00, out_sel = 10, out_zero = 1, out_neg = 0, last_y = 00.
3. Push 8'h81, 8'h7F, 8'h01, 8'hFF (sels 0-3) with out_ready = 0. Expect in_ready = 0 after the 4th push. Hold in_valid 3 more cycles: drop_cnt = 3, last_y = FF. Then drain with out_ready = 1 and expect the order 81/neg=1, 7F, 01, FF/neg=1.
4. Full FIFO with in_valid = 1 and out_ready = 1 in the same cycle. Expect no push that cycle and occupancy 3. The next cycle's push is accepted.
5. Streaming with in_valid = out_ready = 1 for 20 cycles, values 1..20. Expect occupancy steady at 1, outputs lag by 1 cycle, pointers wrap with no loss, drop_cnt = 0.
6. Reset asserted with 3 entries buffered and a push pending. Next cycle expect out_valid = 0, last_y = 0, drop_cnt = 0. Then hold refusals for more than 255 cycles and expect drop_cnt to saturate at FF.
